// File: rtl/aes_pkg.sv
// Shared types and byte/word helpers for the iterative AES-128 encryption core.
package aes_pkg;

   localparam int NR_128 = 10;

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
   typedef logic [127:0] aes_block_t;
   typedef logic [31:0]  aes_word_t;

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      logic [7:0] rc;
      case (rnd)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic aes_word_t mix_column(input aes_word_t w);
      logic [7:0] a0, a1, a2, a3;
      a0 = w[31:24];
      a1 = w[23:16];
      a2 = w[15:8];
      a3 = w[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
   function automatic aes_block_t shift_rows(input aes_block_t s);
      aes_block_t o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
module aes_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);

   always_comb begin
      y_o = 8'h00;
      case (a_i)
         8'h00: y_o = 8'h63; 8'h01: y_o = 8'h7c; 8'h02: y_o = 8'h77; 8'h03: y_o = 8'h7b; 8'h04: y_o = 8'hf2; 8'h05: y_o = 8'h6b; 8'h06: y_o = 8'h6f; 8'h07: y_o = 8'hc5;
         8'h08: y_o = 8'h30; 8'h09: y_o = 8'h01; 8'h0a: y_o = 8'h67; 8'h0b: y_o = 8'h2b; 8'h0c: y_o = 8'hfe; 8'h0d: y_o = 8'hd7; 8'h0e: y_o = 8'hab; 8'h0f: y_o = 8'h76;
         8'h10: y_o = 8'hca; 8'h11: y_o = 8'h82; 8'h12: y_o = 8'hc9; 8'h13: y_o = 8'h7d; 8'h14: y_o = 8'hfa; 8'h15: y_o = 8'h59; 8'h16: y_o = 8'h47; 8'h17: y_o = 8'hf0;
         8'h18: y_o = 8'had; 8'h19: y_o = 8'hd4; 8'h1a: y_o = 8'ha2; 8'h1b: y_o = 8'haf; 8'h1c: y_o = 8'h9c; 8'h1d: y_o = 8'ha4; 8'h1e: y_o = 8'h72; 8'h1f: y_o = 8'hc0;
         8'h20: y_o = 8'hb7; 8'h21: y_o = 8'hfd; 8'h22: y_o = 8'h93; 8'h23: y_o = 8'h26; 8'h24: y_o = 8'h36; 8'h25: y_o = 8'h3f; 8'h26: y_o = 8'hf7; 8'h27: y_o = 8'hcc;
         8'h28: y_o = 8'h34; 8'h29: y_o = 8'ha5; 8'h2a: y_o = 8'he5; 8'h2b: y_o = 8'hf1; 8'h2c: y_o = 8'h71; 8'h2d: y_o = 8'hd8; 8'h2e: y_o = 8'h31; 8'h2f: y_o = 8'h15;
         8'h30: y_o = 8'h04; 8'h31: y_o = 8'hc7; 8'h32: y_o = 8'h23; 8'h33: y_o = 8'hc3; 8'h34: y_o = 8'h18; 8'h35: y_o = 8'h96; 8'h36: y_o = 8'h05; 8'h37: y_o = 8'h9a;
         8'h38: y_o = 8'h07; 8'h39: y_o = 8'h12; 8'h3a: y_o = 8'h80; 8'h3b: y_o = 8'he2; 8'h3c: y_o = 8'heb; 8'h3d: y_o = 8'h27; 8'h3e: y_o = 8'hb2; 8'h3f: y_o = 8'h75;
         8'h40: y_o = 8'h09; 8'h41: y_o = 8'h83; 8'h42: y_o = 8'h2c; 8'h43: y_o = 8'h1a; 8'h44: y_o = 8'h1b; 8'h45: y_o = 8'h6e; 8'h46: y_o = 8'h5a; 8'h47: y_o = 8'ha0;
         8'h48: y_o = 8'h52; 8'h49: y_o = 8'h3b; 8'h4a: y_o = 8'hd6; 8'h4b: y_o = 8'hb3; 8'h4c: y_o = 8'h29; 8'h4d: y_o = 8'he3; 8'h4e: y_o = 8'h2f; 8'h4f: y_o = 8'h84;
         8'h50: y_o = 8'h53; 8'h51: y_o = 8'hd1; 8'h52: y_o = 8'h00; 8'h53: y_o = 8'hed; 8'h54: y_o = 8'h20; 8'h55: y_o = 8'hfc; 8'h56: y_o = 8'hb1; 8'h57: y_o = 8'h5b;
         8'h58: y_o = 8'h6a; 8'h59: y_o = 8'hcb; 8'h5a: y_o = 8'hbe; 8'h5b: y_o = 8'h39; 8'h5c: y_o = 8'h4a; 8'h5d: y_o = 8'h4c; 8'h5e: y_o = 8'h58; 8'h5f: y_o = 8'hcf;
         8'h60: y_o = 8'hd0; 8'h61: y_o = 8'hef; 8'h62: y_o = 8'haa; 8'h63: y_o = 8'hfb; 8'h64: y_o = 8'h43; 8'h65: y_o = 8'h4d; 8'h66: y_o = 8'h33; 8'h67: y_o = 8'h85;
         8'h68: y_o = 8'h45; 8'h69: y_o = 8'hf9; 8'h6a: y_o = 8'h02; 8'h6b: y_o = 8'h7f; 8'h6c: y_o = 8'h50; 8'h6d: y_o = 8'h3c; 8'h6e: y_o = 8'h9f; 8'h6f: y_o = 8'ha8;
         8'h70: y_o = 8'h51; 8'h71: y_o = 8'ha3; 8'h72: y_o = 8'h40; 8'h73: y_o = 8'h8f; 8'h74: y_o = 8'h92; 8'h75: y_o = 8'h9d; 8'h76: y_o = 8'h38; 8'h77: y_o = 8'hf5;
         8'h78: y_o = 8'hbc; 8'h79: y_o = 8'hb6; 8'h7a: y_o = 8'hda; 8'h7b: y_o = 8'h21; 8'h7c: y_o = 8'h10; 8'h7d: y_o = 8'hff; 8'h7e: y_o = 8'hf3; 8'h7f: y_o = 8'hd2;
         8'h80: y_o = 8'hcd; 8'h81: y_o = 8'h0c; 8'h82: y_o = 8'h13; 8'h83: y_o = 8'hec; 8'h84: y_o = 8'h5f; 8'h85: y_o = 8'h97; 8'h86: y_o = 8'h44; 8'h87: y_o = 8'h17;
         8'h88: y_o = 8'hc4; 8'h89: y_o = 8'ha7; 8'h8a: y_o = 8'h7e; 8'h8b: y_o = 8'h3d; 8'h8c: y_o = 8'h64; 8'h8d: y_o = 8'h5d; 8'h8e: y_o = 8'h19; 8'h8f: y_o = 8'h73;
         8'h90: y_o = 8'h60; 8'h91: y_o = 8'h81; 8'h92: y_o = 8'h4f; 8'h93: y_o = 8'hdc; 8'h94: y_o = 8'h22; 8'h95: y_o = 8'h2a; 8'h96: y_o = 8'h90; 8'h97: y_o = 8'h88;
         8'h98: y_o = 8'h46; 8'h99: y_o = 8'hee; 8'h9a: y_o = 8'hb8; 8'h9b: y_o = 8'h14; 8'h9c: y_o = 8'hde; 8'h9d: y_o = 8'h5e; 8'h9e: y_o = 8'h0b; 8'h9f: y_o = 8'hdb;
         8'ha0: y_o = 8'he0; 8'ha1: y_o = 8'h32; 8'ha2: y_o = 8'h3a; 8'ha3: y_o = 8'h0a; 8'ha4: y_o = 8'h49; 8'ha5: y_o = 8'h06; 8'ha6: y_o = 8'h24; 8'ha7: y_o = 8'h5c;
         8'ha8: y_o = 8'hc2; 8'ha9: y_o = 8'hd3; 8'haa: y_o = 8'hac; 8'hab: y_o = 8'h62; 8'hac: y_o = 8'h91; 8'had: y_o = 8'h95; 8'hae: y_o = 8'he4; 8'haf: y_o = 8'h79;
         8'hb0: y_o = 8'he7; 8'hb1: y_o = 8'hc8; 8'hb2: y_o = 8'h37; 8'hb3: y_o = 8'h6d; 8'hb4: y_o = 8'h8d; 8'hb5: y_o = 8'hd5; 8'hb6: y_o = 8'h4e; 8'hb7: y_o = 8'ha9;
         8'hb8: y_o = 8'h6c; 8'hb9: y_o = 8'h56; 8'hba: y_o = 8'hf4; 8'hbb: y_o = 8'hea; 8'hbc: y_o = 8'h65; 8'hbd: y_o = 8'h7a; 8'hbe: y_o = 8'hae; 8'hbf: y_o = 8'h08;
         8'hc0: y_o = 8'hba; 8'hc1: y_o = 8'h78; 8'hc2: y_o = 8'h25; 8'hc3: y_o = 8'h2e; 8'hc4: y_o = 8'h1c; 8'hc5: y_o = 8'ha6; 8'hc6: y_o = 8'hb4; 8'hc7: y_o = 8'hc6;
         8'hc8: y_o = 8'he8; 8'hc9: y_o = 8'hdd; 8'hca: y_o = 8'h74; 8'hcb: y_o = 8'h1f; 8'hcc: y_o = 8'h4b; 8'hcd: y_o = 8'hbd; 8'hce: y_o = 8'h8b; 8'hcf: y_o = 8'h8a;
         8'hd0: y_o = 8'h70; 8'hd1: y_o = 8'h3e; 8'hd2: y_o = 8'hb5; 8'hd3: y_o = 8'h66; 8'hd4: y_o = 8'h48; 8'hd5: y_o = 8'h03; 8'hd6: y_o = 8'hf6; 8'hd7: y_o = 8'h0e;
         8'hd8: y_o = 8'h61; 8'hd9: y_o = 8'h35; 8'hda: y_o = 8'h57; 8'hdb: y_o = 8'hb9; 8'hdc: y_o = 8'h86; 8'hdd: y_o = 8'hc1; 8'hde: y_o = 8'h1d; 8'hdf: y_o = 8'h9e;
         8'he0: y_o = 8'he1; 8'he1: y_o = 8'hf8; 8'he2: y_o = 8'h98; 8'he3: y_o = 8'h11; 8'he4: y_o = 8'h69; 8'he5: y_o = 8'hd9; 8'he6: y_o = 8'h8e; 8'he7: y_o = 8'h94;
         8'he8: y_o = 8'h9b; 8'he9: y_o = 8'h1e; 8'hea: y_o = 8'h87; 8'heb: y_o = 8'he9; 8'hec: y_o = 8'hce; 8'hed: y_o = 8'h55; 8'hee: y_o = 8'h28; 8'hef: y_o = 8'hdf;
         8'hf0: y_o = 8'h8c; 8'hf1: y_o = 8'ha1; 8'hf2: y_o = 8'h89; 8'hf3: y_o = 8'h0d; 8'hf4: y_o = 8'hbf; 8'hf5: y_o = 8'he6; 8'hf6: y_o = 8'h42; 8'hf7: y_o = 8'h68;
         8'hf8: y_o = 8'h41; 8'hf9: y_o = 8'h99; 8'hfa: y_o = 8'h2d; 8'hfb: y_o = 8'h0f; 8'hfc: y_o = 8'hb0; 8'hfd: y_o = 8'h54; 8'hfe: y_o = 8'hbb; 8'hff: y_o = 8'h16;
         default: y_o = 8'h00;
      endcase
   end

endmodule

// File: rtl/aes128_enc_core.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
//
//   state | meaning
//   IDLE  | waiting for a plaintext/key offer, in_ready high
//   ROUND | one cipher round per cycle, rnd 1..NR
//   DONE  | ciphertext held on out_ct until out_ready
module aes128_enc_core
   import aes_pkg::*;
#(
   parameter int NR = NR_128
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_pt,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_ct,
   output logic         busy
);

   if (NR != NR_128) begin : g_nr_check
      $error("aes128_enc_core: NR must be 10 for AES-128");
   end

   state_t     state_q;
   aes_block_t st_q, rk_q, out_ct_q;
   logic [3:0] rnd_q;
   logic       out_valid_q, busy_q;

   aes_block_t sb_st, sr_st, mc_st, st_d, rk_d;
   aes_word_t  rot_w, sub_w, w3_p;
   aes_word_t  w0_n, w1_n, w2_n, w3_n;

   for (genvar i = 0; i < 16; i++) begin : g_subbytes
      aes_sbox u_sbox (.a_i(st_q[127-8*i -: 8]), .y_o(sb_st[127-8*i -: 8]));
   end

   assign rot_w = {rk_q[23:0], rk_q[31:24]};

   for (genvar j = 0; j < 4; j++) begin : g_subword
      aes_sbox u_sbox (.a_i(rot_w[31-8*j -: 8]), .y_o(sub_w[31-8*j -: 8]));
   end

   assign w3_p = sub_w ^ {rcon(rnd_q), 24'h0};
   assign w0_n = rk_q[127:96] ^ w3_p;
   assign w1_n = rk_q[95:64]  ^ w0_n;
   assign w2_n = rk_q[63:32]  ^ w1_n;
   assign w3_n = rk_q[31:0]   ^ w2_n;
   assign rk_d = {w0_n, w1_n, w2_n, w3_n};

   assign sr_st = shift_rows(sb_st);

   always_comb begin
      mc_st = '0;
      for (int c = 0; c < 4; c++) begin
         mc_st[127-32*c -: 32] = mix_column(sr_st[127-32*c -: 32]);
      end
   end

   // Final round drops MixColumns.
   assign st_d = ((rnd_q == 4'(NR)) ? sr_st : mc_st) ^ rk_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         st_q        <= '0;
         rk_q        <= '0;
         rnd_q       <= '0;
         out_ct_q    <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  st_q    <= in_pt ^ in_key;
                  rk_q    <= in_key;
                  rnd_q   <= 4'd1;
                  busy_q  <= 1'b1;
                  state_q <= ROUND;
               end
            end
            ROUND: begin
               rk_q  <= rk_d;
               rnd_q <= rnd_q + 4'd1;
               if (rnd_q == 4'(NR)) begin
                  out_ct_q    <= st_d;
                  out_valid_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= DONE;
               end else begin
                  st_q <= st_d;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Gated by rst_n so nothing is accepted during the reset cycle.
   assign in_ready  = rst_n && (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign out_ct    = out_ct_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_aes128_enc_core.sv
// Self-checking bench for aes128_enc_core against a byte-array AES-128 reference model.
module tb_aes128_enc_core;

   localparam int NR = 10;
   // Accept cycle in IDLE, NR round cycles, one DONE handshake cycle.
   localparam int ACCEPT_PERIOD = NR + 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] in_pt = '0;
   logic [127:0] in_key = '0;
   logic         in_ready, out_valid, busy;
   logic [127:0] out_ct;

   int n_assert = 0;
   int n_fail = 0;

   logic [7:0] sbox_m [256];

   always #5 clk = ~clk;

   aes128_enc_core #(.NR(NR)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_pt(in_pt), .in_key(in_key),
      .out_valid(out_valid), .out_ready(out_ready), .out_ct(out_ct), .busy(busy)
   );

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv, r, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         r = inv; s = inv;
         for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
         end
         sbox_m[x] = s ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [31:0]  tmp;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
            tmp = tmp ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++)
         s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int rnd = 1; rnd <= NR; rnd++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (rnd < NR) begin
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end else begin
               s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
      end
      res = '0;
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Offer a block, wait for accept, then count edges until out_valid.
   task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input string tag,
                            output logic [127:0] ct, output int lat);
      int g;
      in_pt = pt; in_key = key; in_valid = 1'b1;
      g = 0;
      while (!in_ready && g < 50) begin tick(); g++; end
      chk({tag, "_ready"}, 128'(in_ready), 128'(1));
      tick();
      in_valid = 1'b0;
      chk({tag, "_busy"}, 128'(busy), 128'(1));
      lat = 0;
      while (!out_valid && lat < 50) begin tick(); lat++; end
      ct = out_ct;
   endtask

   initial begin
      logic [127:0] ct, pt_a, key_a, exp;
      logic [127:0] exp_q [$];
      int lat, pulses, cyc, last_acc, n_acc, n_out;
      logic acc;

      build_sbox();

      // Reset
      rst_n = 1'b0;
      tick(); tick();
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_out_ct", out_ct, 128'(0));
      chk("rst_st", dut.st_q, 128'(0));
      chk("rst_rk", dut.rk_q, 128'(0));
      chk("rst_rnd", 128'(dut.rnd_q), 128'(0));
      rst_n = 1'b1;
      #1;
      chk("idle_in_ready", 128'(in_ready), 128'(1));

      // FIPS-197 C.1
      run_block(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                "c1", ct, lat);
      chk("c1_ct", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      chk("c1_latency", 128'(lat), 128'(NR));
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // FIPS-197 App. B, plus final round key
      run_block(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                "appb", ct, lat);
      chk("appb_ct", ct, 128'h3925841d02dc09fbdc118597196a0b32);
      chk("appb_rk10", dut.rk_q, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // Backpressure
      pt_a = rand128(); key_a = rand128();
      exp = aes_ref(pt_a, key_a);
      run_block(pt_a, key_a, "bp", ct, lat);
      chk("bp_ct", ct, exp);
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("bp_hold_ct", out_ct, exp);
         chk("bp_hold_valid", 128'(out_valid), 128'(1));
         chk("bp_hold_in_ready", 128'(in_ready), 128'(0));
      end
      out_ready = 1'b1;
      tick();
      chk("bp_release_in_ready", 128'(in_ready), 128'(1));
      chk("bp_release_valid", 128'(out_valid), 128'(0));

      // Offers during ROUND are ignored
      pt_a = rand128(); key_a = rand128();
      exp = aes_ref(pt_a, key_a);
      in_pt = pt_a; in_key = key_a; in_valid = 1'b1;
      tick();
      pulses = 0; ct = '0;
      for (int k = 1; k <= 20; k++) begin
         if (k <= 8) begin
            in_valid = k[0];
            in_pt = rand128();
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (out_valid) begin pulses++; ct = out_ct; end
      end
      chk("ign_ct", ct, exp);
      chk("ign_pulses", 128'(pulses), 128'(1));
      chk("ign_idle_busy", 128'(busy), 128'(0));

      // Reset mid-operation at round 5
      out_ready = 1'b0;
      in_pt = rand128(); in_key = rand128(); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("mid_rnd5", 128'(dut.rnd_q), 128'(5));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("mid_out_valid", 128'(out_valid), 128'(0));
      chk("mid_busy", 128'(busy), 128'(0));
      chk("mid_in_ready", 128'(in_ready), 128'(1));
      run_block(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                "mid_c1", ct, lat);
      chk("mid_c1_ct", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      out_ready = 1'b1; tick();

      // Back-to-back random blocks
      out_ready = 1'b1;
      n_acc = 0; n_out = 0; cyc = 0; last_acc = -1;
      in_pt = rand128(); in_key = rand128(); in_valid = 1'b1;
      while (n_out < 100 && cyc < 3000) begin
         acc = in_valid && in_ready;
         tick();
         cyc++;
         if (acc) begin
            exp_q.push_back(aes_ref(in_pt, in_key));
            if (last_acc >= 0) chk("b2b_gap", 128'(cyc - last_acc), 128'(ACCEPT_PERIOD));
            last_acc = cyc;
            n_acc++;
            if (n_acc < 100) begin
               in_pt = rand128(); in_key = rand128();
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid) begin
            chk("b2b_expected_pending", 128'(exp_q.size() > 0), 128'(1));
            if (exp_q.size() > 0) chk("b2b_ct", out_ct, exp_q.pop_front());
            n_out++;
         end
      end
      chk("b2b_out_count", 128'(n_out), 128'(100));
      chk("b2b_acc_count", 128'(n_acc), 128'(100));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
